// File: rtl/enc_pkg.sv
// Shared types and helpers for the quadrature angle decoder.
// AB is packed as {B, A}; forward Gray order is 00 -> 01 -> 11 -> 10.
package enc_pkg;

  localparam int COUNTS_PER_REV_DEFAULT = 1006;

  typedef logic [11:0] angle_t;

  typedef enum logic {PRIME, TRACK} qdec_state_t;

  typedef enum logic [1:0] {
    Q00 = 2'b00,
    Q01 = 2'b01,
    Q11 = 2'b11,
    Q10 = 2'b10
  } gray_t;

  // Forward successor of an AB code in the Gray cycle.
  function automatic logic [1:0] gray_fwd(input logic [1:0] q);
    case (q)
      Q00:     gray_fwd = Q01;
      Q01:     gray_fwd = Q11;
      Q11:     gray_fwd = Q10;
      default: gray_fwd = Q00;
    endcase
  endfunction

endpackage

// File: rtl/quadrature_angle_counter_input_filter.sv
// Per-pin synchroniser followed by a glitch filter: the level follows the
// synchronised sample only after FILTER_LEN consecutive samples agree.
module input_filter
  import enc_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic stable
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);
  localparam logic [CW-1:0] FULL = CW'(FILTER_LEN);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          diff_cnt;
  logic [CW-1:0]          same_cnt;
  logic                   smp;

  assign smp    = sync[SYNC_STAGES-1];
  assign stable = (same_cnt == FULL);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync     <= '0;
      level    <= 1'b0;
      diff_cnt <= '0;
      same_cnt <= '0;
    end else begin
      sync[0] <= pin;
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];

      if (smp == level) begin
        diff_cnt <= '0;
        if (same_cnt != FULL) same_cnt <= same_cnt + CW'(1);
      end else begin
        // any disagreeing sample restarts the quiet-time measurement
        same_cnt <= '0;
        if (diff_cnt == LAST) begin
          level    <= smp;
          diff_cnt <= '0;
        end else begin
          diff_cnt <= diff_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/quadrature_angle_counter.sv
// Quadrature decoder: filtered A/B/index drive a modulo-COUNTS_PER_REV angle
// counter with direction, step strobe and a sticky illegal-transition flag.
module quadrature_angle_counter
  import enc_pkg::*;
#(
  parameter int COUNTS_PER_REV = COUNTS_PER_REV_DEFAULT,
  parameter int WIDTH          = 12,
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             enc_index,
  input  logic             zero_req,
  input  logic             error_clr,
  output logic [WIDTH-1:0] angle,
  output logic             direction,
  output logic             step,
  output logic             error
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(COUNTS_PER_REV - 1);

  logic [2:0] pins, filt, stab;
  assign pins = {enc_index, enc_b, enc_a};

  input_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_filt [2:0] (
    .clk   (clk),
    .reset (reset),
    .pin   (pins),
    .level (filt),
    .stable(stab)
  );

  qdec_state_t      state, state_nx;
  logic [1:0]       prev_ab, prev_ab_nx, cur_ab;
  logic             prev_idx, prev_idx_nx;
  logic [WIDTH-1:0] angle_nx;
  logic             direction_nx, step_nx, error_nx;
  logic             fwd, rev, bad, idx_rise;

  assign cur_ab = filt[1:0];

  always_comb begin
    fwd      = (cur_ab == gray_fwd(prev_ab));
    rev      = (prev_ab == gray_fwd(cur_ab));
    bad      = ((cur_ab ^ prev_ab) == 2'b11);
    idx_rise = filt[2] & ~prev_idx;

    state_nx     = state;
    prev_ab_nx   = prev_ab;
    prev_idx_nx  = prev_idx;
    angle_nx     = angle;
    direction_nx = direction;
    step_nx      = 1'b0;
    error_nx     = error & ~error_clr;

    case (state)
      PRIME: begin
        if (&stab) begin
          state_nx    = TRACK;
          prev_ab_nx  = cur_ab;
          prev_idx_nx = filt[2];
        end
      end
      default: begin
        prev_ab_nx  = cur_ab;
        prev_idx_nx = filt[2];
        if (fwd) begin
          angle_nx     = (angle == MAXV) ? '0 : angle + WIDTH'(1);
          direction_nx = 1'b1;
          step_nx      = 1'b1;
        end else if (rev) begin
          angle_nx     = (angle == '0) ? MAXV : angle - WIDTH'(1);
          direction_nx = 1'b0;
          step_nx      = 1'b1;
        end else if (bad) begin
          error_nx = 1'b1;
        end
        if (idx_rise) angle_nx = '0;
      end
    endcase

    if (zero_req) angle_nx = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= PRIME;
      prev_ab   <= '0;
      prev_idx  <= 1'b0;
      angle     <= '0;
      direction <= 1'b0;
      step      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state     <= state_nx;
      prev_ab   <= prev_ab_nx;
      prev_idx  <= prev_idx_nx;
      angle     <= angle_nx;
      direction <= direction_nx;
      step      <= step_nx;
      error     <= error_nx;
    end
  end

endmodule

// File: tb/tb_quadrature_angle_counter.sv
// Bench for quadrature_angle_counter: directed scenarios plus a random walk,
// checked against a sample-history model of the pins and a modulo angle model.
module tb_quadrature_angle_counter;

  localparam int N  = 1006;
  localparam int FL = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enc_a = 1'b0, enc_b = 1'b0, enc_index = 1'b0;
  logic        zero_req = 1'b0, error_clr = 1'b0;
  logic [11:0] angle;
  logic        direction, step, error;

  int checks = 0;
  int failures = 0;

  quadrature_angle_counter dut (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .enc_index(enc_index),
    .zero_req(zero_req), .error_clr(error_clr),
    .angle(angle), .direction(direction), .step(step), .error(error)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_angle, m_dir, m_step, m_err, m_track, m_pc;
  int m_prev_pos, m_prev_idx;
  int p1[3], p2[3], run_len[3], last_smp[3], flt[3];
  int tb_pos = 0;

  function automatic int ab_pos(input int b, input int a);
    case ({b[0], a[0]})
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] gray_of(input int p);
    case (p & 3)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  // Model of one clock edge using the inputs the DUT sees at that edge.
  task automatic model_edge();
    int pin_now[3];
    int d, smp;
    pin_now[0] = int'(enc_a); pin_now[1] = int'(enc_b); pin_now[2] = int'(enc_index);
    if (reset) begin
      m_angle = 0; m_dir = 0; m_step = 0; m_err = 0; m_track = 0; m_pc = 0;
      for (int i = 0; i < 3; i++) begin
        p1[i] = 0; p2[i] = 0; run_len[i] = 0; last_smp[i] = 0; flt[i] = 0;
      end
    end else begin
      m_step = 0;
      if (error_clr) m_err = 0;
      if (!m_track) begin
        // pins are always held still long enough after reset for the filters to settle
        m_pc++;
        if (m_pc >= 16) begin
          m_track = 1; m_prev_pos = ab_pos(flt[1], flt[0]); m_prev_idx = flt[2];
        end
      end else begin
        d = (ab_pos(flt[1], flt[0]) - m_prev_pos) & 3;
        if (d == 1) begin m_angle = (m_angle + 1) % N; m_dir = 1; m_step = 1; end
        else if (d == 3) begin m_angle = (m_angle + N - 1) % N; m_dir = 0; m_step = 1; end
        else if (d == 2) m_err = 1;
        if (flt[2] == 1 && m_prev_idx == 0) m_angle = 0;
        m_prev_pos = ab_pos(flt[1], flt[0]);
        m_prev_idx = flt[2];
      end
      if (zero_req) m_angle = 0;
      for (int i = 0; i < 3; i++) begin
        smp = p2[i]; p2[i] = p1[i]; p1[i] = pin_now[i];
        if (smp == last_smp[i]) run_len[i]++;
        else begin run_len[i] = 1; last_smp[i] = smp; end
        if (run_len[i] >= FL) flt[i] = smp;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    zero_req = 1'b0;
    error_clr = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic set_ab(input logic [1:0] ab);
    enc_b = ab[1];
    enc_a = ab[0];
  endtask

  task automatic move(input int fwd, input int gap);
    tb_pos = (tb_pos + (fwd != 0 ? 1 : 3)) & 3;
    set_ab(gray_of(tb_pos));
    run(gap);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    run(2);
    reset = 1'b0;
    checks += 4;
    if (angle !== 12'd0)   begin failures++; $display("FAIL reset_angle: got %0d want 0", angle); end
    if (direction !== 1'b0) begin failures++; $display("FAIL reset_dir: got %b want 0", direction); end
    if (step !== 1'b0)      begin failures++; $display("FAIL reset_step: got %b want 0", step); end
    if (error !== 1'b0)     begin failures++; $display("FAIL reset_error: got %b want 0", error); end
    run(20);
  endtask

  task automatic test_forward();
    int pulses, at;
    for (int s = 0; s < 4; s++) begin
      tb_pos = (tb_pos + 1) & 3;
      set_ab(gray_of(tb_pos));
      pulses = 0; at = -1;
      for (int t = 1; t <= 20; t++) begin
        tick();
        if (step === 1'b1) begin pulses++; at = t; end
      end
      checks += 2;
      if (pulses != 1) begin failures++; $display("FAIL fwd_pulses: got %0d want 1", pulses); end
      if (at != 7)     begin failures++; $display("FAIL fwd_latency: got %0d want 7", at); end
    end
    checks += 3;
    if (angle !== 12'd4)          begin failures++; $display("FAIL fwd_angle: got %0d want 4", angle); end
    if (angle !== 12'(m_angle))   begin failures++; $display("FAIL fwd_model: got %0d want %0d", angle, m_angle); end
    if (direction !== 1'b1)       begin failures++; $display("FAIL fwd_dir: got %b want 1", direction); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 1001; i++) move(1, 10);
    checks++;
    if (angle !== 12'd1005) begin failures++; $display("FAIL wrap_pre: got %0d want 1005", angle); end
    move(1, 10);
    checks++;
    if (angle !== 12'd0) begin failures++; $display("FAIL wrap_fwd: got %0d want 0", angle); end
    move(0, 10);
    checks += 2;
    if (angle !== 12'd1005) begin failures++; $display("FAIL wrap_rev: got %0d want 1005", angle); end
    if (direction !== 1'b0) begin failures++; $display("FAIL wrap_dir: got %b want 0", direction); end
  endtask

  task automatic test_glitch();
    int base, steps;
    while (tb_pos != 0) move(0, 10);
    base = m_angle; steps = 0;
    enc_a = 1'b1;
    for (int t = 0; t < 3; t++) begin tick(); if (step === 1'b1) steps++; end
    enc_a = 1'b0;
    for (int t = 0; t < 15; t++) begin tick(); if (step === 1'b1) steps++; end
    checks += 3;
    if (angle !== 12'(base)) begin failures++; $display("FAIL glitch_angle: got %0d want %0d", angle, base); end
    if (steps != 0)          begin failures++; $display("FAIL glitch_step: got %0d want 0", steps); end
    if (error !== 1'b0)      begin failures++; $display("FAIL glitch_error: got %b want 0", error); end
    enc_a = 1'b1;
    for (int t = 0; t < 4; t++) begin tick(); if (step === 1'b1) steps++; end
    enc_a = 1'b0;
    for (int t = 0; t < 15; t++) begin tick(); if (step === 1'b1) steps++; end
    checks += 3;
    if (steps != 2)          begin failures++; $display("FAIL pulse_steps: got %0d want 2", steps); end
    if (angle !== 12'(base)) begin failures++; $display("FAIL pulse_angle: got %0d want %0d", angle, base); end
    if (direction !== 1'b0)  begin failures++; $display("FAIL pulse_dir: got %b want 0", direction); end
  endtask

  task automatic test_error();
    int base;
    base = m_angle;
    tb_pos = 2; set_ab(2'b11);
    run(12);
    checks += 2;
    if (error !== 1'b1)      begin failures++; $display("FAIL err_set: got %b want 1", error); end
    if (angle !== 12'(base)) begin failures++; $display("FAIL err_angle: got %0d want %0d", angle, base); end
    error_clr = 1'b1;
    tick();
    checks++;
    if (error !== 1'b0) begin failures++; $display("FAIL err_clr: got %b want 0", error); end
    tb_pos = 1; set_ab(2'b01);
    run(10);
    tb_pos = 3; set_ab(2'b10);
    run(6);
    error_clr = 1'b1;
    tick();
    checks += 2;
    if (error !== 1'b1)         begin failures++; $display("FAIL err_set_wins: got %b want 1", error); end
    if (angle !== 12'(m_angle)) begin failures++; $display("FAIL err_model: got %0d want %0d", angle, m_angle); end
    error_clr = 1'b1;
    tick();
    checks++;
    if (error !== 1'b0) begin failures++; $display("FAIL err_clr2: got %b want 0", error); end
  endtask

  task automatic test_index();
    zero_req = 1'b1;
    tick();
    for (int i = 0; i < 500; i++) move(1, 8);
    checks++;
    if (angle !== 12'd500) begin failures++; $display("FAIL idx_pre: got %0d want 500", angle); end
    tb_pos = (tb_pos + 1) & 3;
    set_ab(gray_of(tb_pos));
    enc_index = 1'b1;
    run(7);
    checks += 3;
    if (angle !== 12'd0)    begin failures++; $display("FAIL idx_angle: got %0d want 0", angle); end
    if (step !== 1'b1)      begin failures++; $display("FAIL idx_step: got %b want 1", step); end
    if (direction !== 1'b1) begin failures++; $display("FAIL idx_dir: got %b want 1", direction); end
    run(10);
    enc_index = 1'b0;
    run(12);
    move(1, 10);
    checks++;
    if (angle !== 12'd1) begin failures++; $display("FAIL idx_after: got %0d want 1", angle); end
    move(1, 10);
    enc_index = 1'b1;
    run(6);
    zero_req = 1'b1;
    tick();
    checks++;
    if (angle !== 12'd0) begin failures++; $display("FAIL idx_zero: got %0d want 0", angle); end
    run(10);
    enc_index = 1'b0;
    run(12);
  endtask

  task automatic test_reset_mid();
    int steps = 0;
    zero_req = 1'b1;
    tick();
    for (int i = 0; i < 37; i++) move(1, 8);
    checks++;
    if (angle !== 12'd37) begin failures++; $display("FAIL rmid_pre: got %0d want 37", angle); end
    tb_pos = (tb_pos + 1) & 3;
    set_ab(gray_of(tb_pos));
    run(3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks += 3;
    if (angle !== 12'd0)  begin failures++; $display("FAIL rmid_angle: got %0d want 0", angle); end
    if (step !== 1'b0)    begin failures++; $display("FAIL rmid_step: got %b want 0", step); end
    if (dut.state !== enc_pkg::PRIME) begin failures++; $display("FAIL rmid_state: got %0d want PRIME", dut.state); end
    for (int t = 0; t < 30; t++) begin tick(); if (step === 1'b1) steps++; end
    checks += 2;
    if (steps != 0)      begin failures++; $display("FAIL rmid_nocount: got %0d want 0", steps); end
    if (angle !== 12'd0) begin failures++; $display("FAIL rmid_hold: got %0d want 0", angle); end
    move(1, 10);
    checks++;
    if (angle !== 12'd1) begin failures++; $display("FAIL rmid_resume: got %0d want 1", angle); end
  endtask

  task automatic test_random_walk();
    int gap, zat, bad;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      gap = int'($urandom_range(6, 12));
      zat = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 11)) : -1;
      if ($urandom_range(0, 7) == 0) enc_index = ~enc_index;
      tb_pos = (tb_pos + (($urandom_range(0, 1) == 1) ? 1 : 3)) & 3;
      set_ab(gray_of(tb_pos));
      for (int t = 0; t < gap; t++) begin
        if (t == zat) zero_req = 1'b1;
        tick();
        checks++;
        if (angle !== 12'(m_angle) || step !== 1'(m_step) ||
            direction !== 1'(m_dir) || error !== 1'(m_err)) begin
          failures++;
          if (bad < 10)
            $display("FAIL walk: got a=%0d s=%b d=%b e=%b want a=%0d s=%0d d=%0d e=%0d",
                     angle, step, direction, error, m_angle, m_step, m_dir, m_err);
          bad++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_wrap();
    test_glitch();
    test_error();
    test_index();
    test_reset_mid();
    test_random_walk();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
